// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit after EX; single-outstanding data bus, lane alignment, load extension, writeback.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_memaddr,
    input  logic [3:0]  ex_memrden,
    input  logic        ex_memrden_sext,
    input  logic [3:0]  ex_memwren,
    input  logic [31:0] ex_memwrdata,
    input  logic        ex_x_rd_vld,
    input  logic [31:0] ex_x_rd,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        stall,
    output logic        mem_x_rd_vld,
    output logic [31:0] mem_x_rd,
    output logic        mem_err,
    output logic [1:0]  mem_err_code,
    output logic [31:0] mem_err_addr
);
    typedef enum logic {IDLE, BUS} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  shift_q, shift_d, size_q, size_d;
    logic        sext_q, sext_d;
    logic        req_q, req_d, we_q, we_d, vld_q, vld_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d, eaddr_q, eaddr_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  code_q, code_d;
    logic [3:0]  mask;
    logic        mem_op, bad_mask, misal, legal;
    logic [31:0] shifted, load;

    // A request carries either a load or a store mask; both at once is illegal.
    assign mask     = |ex_memrden ? ex_memrden : ex_memwren;
    assign mem_op   = |ex_memrden | |ex_memwren;
    assign bad_mask = (|ex_memrden & |ex_memwren) | !(mask == 4'b0001 || mask == 4'b0011 || mask == 4'b1111);
    assign misal    = (mask == 4'b0011 & ex_memaddr[0]) | (mask == 4'b1111 & |ex_memaddr[1:0]);
    assign legal    = mem_op & !bad_mask & !misal;
    assign stall    = (state_q == BUS) | legal;
    assign shifted  = dbus_rdata >> {shift_q, 3'b000};
    assign load     = size_q == 2'd2 ? shifted :
                      size_q == 2'd1 ? {{16{sext_q & shifted[15]}}, shifted[15:0]} :
                                       {{24{sext_q & shifted[7]}}, shifted[7:0]};

    assign dbus_req     = req_q;
    assign dbus_we      = we_q;
    assign dbus_addr    = addr_q;
    assign dbus_be      = be_q;
    assign dbus_wdata   = wdata_q;
    assign mem_x_rd_vld = vld_q;
    assign mem_x_rd     = rd_q;
    assign mem_err      = err_q;
    assign mem_err_code = code_q;
    assign mem_err_addr = eaddr_q;

    // Next state: accept ALU results or issue a bus request in IDLE, wait for ack or timeout in BUS.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        size_d  = size_q;
        sext_d  = sext_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        vld_d   = 1'b0;
        rd_d    = rd_q;
        err_d   = 1'b0;
        code_d  = code_q;
        eaddr_d = eaddr_q;
        if (state_q == IDLE) begin
            if (!mem_op) begin
                vld_d = ex_x_rd_vld;
                rd_d  = ex_x_rd_vld ? ex_x_rd : rd_q;
            end else if (!legal) begin
                err_d   = 1'b1;
                code_d  = bad_mask ? 2'b10 : 2'b01;
                eaddr_d = ex_memaddr;
            end else begin
                state_d = BUS;
                cnt_d   = 8'd0;
                req_d   = 1'b1;
                we_d    = |ex_memwren;
                addr_d  = {ex_memaddr[31:2], 2'b00};
                be_d    = mask << ex_memaddr[1:0];
                wdata_d = ex_memwrdata << {ex_memaddr[1:0], 3'b000};
                shift_d = ex_memaddr[1:0];
                size_d  = mask[3] ? 2'd2 : mask[1] ? 2'd1 : 2'd0;
                sext_d  = ex_memrden_sext;
            end
        end else if (dbus_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
            vld_d   = !we_q;
            rd_d    = we_q ? rd_q : load;
        end else if (cnt_q + 8'd1 == 8'(ACK_TIMEOUT)) begin
            state_d = IDLE;
            req_d   = 1'b0;
            err_d   = 1'b1;
            code_d  = 2'b11;
            eaddr_d = {addr_q[31:2], shift_q};
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State and output registers; reset aborts any pending transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            vld_q   <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            vld_q   <= vld_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            code_q  <= code_d;
            eaddr_q <= eaddr_d;
        end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit sitting directly after the Execute stage: consumes the registered EX memory request (address, unshifted byte mask, sign-extension flag, store data) and the EX ALU writeback. Drives a single-outstanding data-bus request/acknowledge handshake, aligns byte lanes, sign/zero-extends load data and produces the final register writeback. Asserts a stall back to fetch/decode/execute while a bus transaction is pending.

## Interface
Parameters:
- ACK_TIMEOUT, 255: max cycles `dbus_req` is held without `dbus_ack` before aborting (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_memaddr  in  32  byte address from EX
- ex_memrden  in  4  load mask, unshifted: 0001 byte, 0011 half, 1111 word
- ex_memrden_sext  in  1  load sign-extend (lb/lh vs lbu/lhu)
- ex_memwren  in  4  store mask, same encoding
- ex_memwrdata  in  32  store data, right-justified
- ex_x_rd_vld  in  1  EX writeback valid (set for ALU ops and loads)
- ex_x_rd  in  32  EX ALU result
- dbus_req  out  1  bus request, held until ack
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_be  out  4  lane byte enables
- dbus_wdata  out  32  lane-shifted store data
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  one-cycle completion strobe
- stall  out  1  freeze upstream stages (combinational)
- mem_x_rd_vld  out  1  writeback valid, one-cycle pulse
- mem_x_rd  out  32  writeback data
- mem_err  out  1  error pulse
- mem_err_code  out  2  01 misaligned, 10 illegal mask, 11 bus timeout
- mem_err_addr  out  32  offending ex_memaddr

## Operation
- States: IDLE, BUS. Inputs sampled only in IDLE; ignored in BUS (upstream frozen by `stall`).
- IDLE, no mask set: if ex_x_rd_vld, register ex_x_rd to mem_x_rd, pulse mem_x_rd_vld.
- IDLE, mask set: decode size. Both rden and wren nonzero, or mask not in {0001,0011,1111} -> err code 10. Half with addr[0]=1, word with addr[1:0]!=0 -> err code 01. Errors: no bus request, no writeback, stay IDLE.
- Legal request: dbus_be = mask << addr[1:0]; dbus_wdata = wrdata << 8*addr[1:0]; dbus_we = |wren; latch shift, size, sext; go BUS with dbus_req=1.
- BUS: on dbus_ack drop req, return IDLE. Load: data = rdata >> 8*shift, truncate to size, extend per sext, pulse mem_x_rd_vld. Store: no writeback.
- Timeout counter cleared on entry to BUS, increments each BUS cycle without ack; at ACK_TIMEOUT drop req, err code 11, no writeback, IDLE.
- stall = (state==BUS) | (state==IDLE & legal mem request present).
- dbus_ack in IDLE ignored. ack on timeout cycle counts as completion.
- Reset values: dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata, mem_x_rd_vld, mem_x_rd, mem_err, mem_err_code, mem_err_addr all 0; state IDLE; counter 0.

## Timing
- ALU passthrough: 1 cycle (sampled edge N, mem_x_rd_vld high N+1).
- Memory: sample edge N -> dbus_req high from N+1; ack sampled edge M (M>=N+1) -> req low and mem_x_rd_vld high after edge M. Zero-wait load: 2 cycles.
- stall high from sample cycle through the ack cycle; low the cycle mem_x_rd_vld pulses.
- Errors: mem_err pulses 1 cycle after sample edge (timeout: after ACK_TIMEOUT-th BUS cycle).
- Async reset mid-BUS: req drops immediately, no writeback, no error; next request after rst_n release proceeds normally.

## Test plan
- LW addr 0x100, ack in first req cycle, rdata 0xDEADBEEF -> dbus_addr 0x100, be 1111, we 0; mem_x_rd 0xDEADBEEF 2 cycles after sample; stall high exactly 2 cycles.
- LH addr 0x102 sext=1, rdata 0x8001_1234 -> be 1100, mem_x_rd 0xFFFF8001; same with sext=0 -> 0x00008001; lb addr 0x103 rdata 0x7F000000 sext=1 -> 0x0000007F.
- Store byte mask 0001 addr 0x203 wrdata 0xAB, ack after 3 wait cycles -> dbus_addr 0x200, be 1000, wdata 0xAB000000, req held 4 cycles, no mem_x_rd_vld.
- LW addr 0x101 -> no dbus_req, mem_err code 01 addr 0x101; mask 0111 -> code 10; rden and wren both set -> code 10.
- ACK_TIMEOUT=4, no ack -> req high exactly 4 cycles, mem_err code 11, stall released; subsequent ADD passthrough 0x55 -> mem_x_rd 0x55 next cycle.
- rst_n low during BUS -> all outputs 0 asynchronously; late ack after reset ignored; next LW completes correctly.
